// File: rtl/secret_flow_decrypt.sv
// Receive-side secret-flow cipher: buffers words in a small fallthrough FIFO,
// validates IPv4/UDP headers and XOR-decrypts the UDP payload with a per-packet key.

module secret_flow_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             nearly_full
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   FULL_LEVEL = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0]   COUNT_ONE  = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  full;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty       = (count == '0);
    assign full        = (count == FULL_LEVEL);
    assign nearly_full = (count >= (FULL_LEVEL - COUNT_ONE));
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Storage is not reset; flushing only needs the pointers and occupancy cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module secret_flow_decrypt #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int CNT_WIDTH       = 32,
    parameter int ZERO_UDP_CSUM   = 1,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [31:0]           key,
    input  logic                  enable,
    output logic [CNT_WIDTH-1:0]  decrypt_cnt,
    output logic [CNT_WIDTH-1:0]  bypass_cnt
);
    localparam logic [2:0] S_MOD_HDR = 3'd0;
    localparam logic [2:0] S_ETH_IP  = 3'd1;
    localparam logic [2:0] S_UDP_HDR = 3'd2;
    localparam logic [2:0] S_XOR     = 3'd3;
    localparam logic [2:0] S_PASS    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] head_word;
    logic [DATA_WIDTH-1:0]            head_data;
    logic [CTRL_WIDTH-1:0]            head_ctrl;
    logic                             fifo_empty;
    logic                             fifo_nearly_full;
    logic                             rd_en;
    logic                             head_is_body;

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [2:0]            word_idx;
    logic [31:0]           key_l;
    logic                  pkt_ok;
    logic                  eth_hdr_ok;
    logic                  proto_ok;
    logic [DATA_WIDTH-1:0] key_mask;
    logic [DATA_WIDTH-1:0] csum_word;
    logic [DATA_WIDTH-1:0] proc_data;
    logic                  count_decrypt;
    logic                  count_bypass;
    logic                  pkt_last;

    secret_flow_fifo #(
        .WIDTH      (CTRL_WIDTH + DATA_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_data     ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (rd_en),
        .rd_data     (head_word),
        .empty       (fifo_empty),
        .nearly_full (fifo_nearly_full)
    );

    assign in_rdy       = !fifo_nearly_full;
    assign rd_en        = !fifo_empty && out_rdy;
    assign head_ctrl    = head_word[DATA_WIDTH +: CTRL_WIDTH];
    assign head_data    = head_word[DATA_WIDTH-1:0];
    assign head_is_body = (head_ctrl == '0);

    assign eth_hdr_ok = (head_data[31:16] == 16'h0800) && (head_data[15:8] == 8'h45);
    assign proto_ok   = (head_data[7:0] == 8'h11);
    assign key_mask   = {key_l, key_l};
    assign csum_word  = {(ZERO_UDP_CSUM != 0) ? 16'h0000 : head_data[63:48],
                         head_data[47:0] ^ {key_l[15:0], key_l}};
    assign pkt_last   = count_decrypt || count_bypass;

    // A ctrl!=0 word outside MOD_HDR always ends the packet; in ETH_IP/UDP_HDR it is a runt.
    always_comb begin
        next_state    = state;
        proc_data     = head_data;
        count_decrypt = 1'b0;
        count_bypass  = 1'b0;
        case (state)
            S_MOD_HDR: begin
                if (head_is_body) begin
                    next_state = S_ETH_IP;
                end
            end
            S_ETH_IP: begin
                if (!head_is_body) begin
                    next_state   = S_MOD_HDR;
                    count_bypass = 1'b1;
                end else if (word_idx == 3'd3) begin
                    next_state = (pkt_ok && proto_ok) ? S_UDP_HDR : S_PASS;
                end
            end
            S_UDP_HDR: begin
                if (!head_is_body) begin
                    next_state   = S_MOD_HDR;
                    count_bypass = 1'b1;
                end else if (word_idx == 3'd6) begin
                    proc_data  = csum_word;
                    next_state = S_XOR;
                end
            end
            S_XOR: begin
                proc_data = head_data ^ key_mask;
                if (!head_is_body) begin
                    next_state    = S_MOD_HDR;
                    count_decrypt = 1'b1;
                end
            end
            S_PASS: begin
                if (!head_is_body) begin
                    next_state   = S_MOD_HDR;
                    count_bypass = 1'b1;
                end
            end
            default: begin
                next_state = S_MOD_HDR;
            end
        endcase
    end

    // Key and enable are sampled once, at the packet's first ctrl==0 word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_MOD_HDR;
            word_idx <= 3'd1;
            key_l    <= '0;
            pkt_ok   <= 1'b0;
        end else if (rd_en) begin
            state <= next_state;
            if (state == S_MOD_HDR && head_is_body) begin
                key_l    <= key;
                pkt_ok   <= enable;
                word_idx <= 3'd2;
            end else if ((state == S_ETH_IP || state == S_UDP_HDR) && head_is_body) begin
                word_idx <= word_idx + 3'd1;
                if (state == S_ETH_IP && word_idx == 3'd2) begin
                    pkt_ok <= pkt_ok && eth_hdr_ok;
                end
            end
            if (pkt_last) begin
                word_idx <= 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= rd_en;
            if (rd_en) begin
                out_data <= proc_data;
                out_ctrl <= head_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decrypt_cnt <= '0;
            bypass_cnt  <= '0;
        end else if (rd_en) begin
            if (count_decrypt) begin
                decrypt_cnt <= decrypt_cnt + CNT_ONE;
            end
            if (count_bypass) begin
                bypass_cnt <= bypass_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_secret_flow_decrypt.sv
// Bench for secret_flow_decrypt: random packets checked against a packet-level
// cipher model, plus directed UDP/TCP/runt/stall/reset scenarios.

module tb_secret_flow_decrypt;
    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [31:0] key;
    logic        enable;
    logic [31:0] decrypt_cnt;
    logic [31:0] bypass_cnt;

    secret_flow_decrypt dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_wr       (in_wr),
        .in_rdy      (in_rdy),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .out_wr      (out_wr),
        .out_rdy     (out_rdy),
        .key         (key),
        .enable      (enable),
        .decrypt_cnt (decrypt_cnt),
        .bypass_cnt  (bypass_cnt)
    );

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [63:0] data;
        bit          first;
        bit          last;
        int          dec;
        int          byp;
    } exp_t;

    exp_t        expq[$];
    int          compared     = 0;
    int          mismatched   = 0;
    int          first_seen   = 0;
    int          pkts_started = 0;
    int          model_dec    = 0;
    int          model_byp    = 0;
    int          rdy_mode     = 0;
    logic [7:0]  pkt_ctrl [64];
    logic [63:0] pkt_data [64];
    logic [63:0] mdl_data [64];
    int          pkt_len;
    int          pkt_first;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = !out_rdy;
                default: out_rdy = ($urandom % 4) != 0;
            endcase
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired, required completion", name);
    endtask

    // Every output word is compared against the head of the expected stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_wr) begin
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_word: got %h/%h, required no word", out_ctrl, out_data);
                end else begin
                    e = expq.pop_front();
                    check_output("out_data", out_data, e.data);
                    check_output("out_ctrl", {56'h0, out_ctrl}, {56'h0, e.ctrl});
                    if (e.first) first_seen++;
                    if (e.last) begin
                        check_output("decrypt_cnt", {32'h0, decrypt_cnt}, {32'h0, e.dec});
                        check_output("bypass_cnt", {32'h0, bypass_cnt}, {32'h0, e.byp});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog");
    end

    // kind: 0 UDP, 1 TCP, 2 IPv6 ethertype, 3 bad IHL
    task automatic gen_packet(input int kind, input int nhdr, input int nb);
        logic [63:0] d;
        pkt_len = 0;
        for (int i = 0; i < nhdr; i++) begin
            pkt_ctrl[pkt_len] = 8'hFF;
            pkt_data[pkt_len] = {$urandom, $urandom};
            pkt_len++;
        end
        pkt_first = pkt_len;
        for (int n = 1; n <= nb; n++) begin
            d = {$urandom, $urandom};
            if (n == 2) begin
                d[31:16] = (kind == 2) ? 16'h86DD : 16'h0800;
                d[15:8]  = (kind == 3) ? 8'h46 : 8'h45;
            end
            if (n == 3) d[7:0] = (kind == 1) ? 8'h06 : 8'h11;
            pkt_ctrl[pkt_len] = 8'h00;
            pkt_data[pkt_len] = d;
            pkt_len++;
        end
        pkt_ctrl[pkt_len] = 8'h01 << ($urandom % 8);
        pkt_data[pkt_len] = {$urandom, $urandom};
        pkt_len++;
    endtask

    // Packet-level rule: decrypt only a complete, enabled IPv4/UDP packet with word 6 present.
    task automatic model_packet(input logic [31:0] k, input bit en, output bit dec);
        int nb;
        int w6;
        nb  = pkt_len - pkt_first - 1;
        w6  = pkt_first + 5;
        dec = en && (nb >= 6)
              && (pkt_data[pkt_first+1][31:16] == 16'h0800)
              && (pkt_data[pkt_first+1][15:8] == 8'h45)
              && (pkt_data[pkt_first+2][7:0] == 8'h11);
        for (int i = 0; i < pkt_len; i++) mdl_data[i] = pkt_data[i];
        if (dec) begin
            mdl_data[w6] = {16'h0000, pkt_data[w6][47:0] ^ {k[15:0], k}};
            for (int i = w6 + 1; i < pkt_len; i++) mdl_data[i] = pkt_data[i] ^ {k, k};
        end
    endtask

    task automatic push_expected(input int upto);
        exp_t e;
        for (int i = 0; i < upto; i++) begin
            e.ctrl  = pkt_ctrl[i];
            e.data  = mdl_data[i];
            e.first = (i == pkt_first);
            e.last  = (i == pkt_len - 1);
            e.dec   = model_dec;
            e.byp   = model_byp;
            expq.push_back(e);
        end
    endtask

    task automatic write_word(input logic [7:0] c, input logic [63:0] d);
        int guard = 0;
        while (!in_rdy && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) timeout_fail("in_rdy_wait");
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
        @(posedge clk);
        #1;
        in_wr = 1'b0;
        if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_first_seen(input int target);
        int guard = 0;
        while (first_seen < target && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) timeout_fail("first_word_wait");
    endtask

    // scramble: 0 none, 1 random key/enable, 2 key forced to zero, applied mid-packet
    task automatic apply_stimulus(input logic [31:0] k, input bit en, input int scramble);
        bit dec;
        int my_idx;
        wait_first_seen(pkts_started);
        my_idx = pkts_started;
        pkts_started++;
        key    = k;
        enable = en;
        model_packet(k, en, dec);
        if (dec) model_dec++;
        else     model_byp++;
        push_expected(pkt_len);
        fork
            begin
                for (int i = 0; i < pkt_len; i++) write_word(pkt_ctrl[i], pkt_data[i]);
            end
            begin
                if (scramble != 0) begin
                    wait_first_seen(my_idx + 1);
                    repeat ((scramble == 2) ? 12 : ($urandom % 10)) @(posedge clk);
                    #1;
                    key    = (scramble == 2) ? 32'h0 : $urandom;
                    enable = ($urandom % 2) != 0;
                end
            end
        join
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (expq.size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 3000) timeout_fail("drain_wait");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit dec;
        reset   = 1'b0;
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        key     = '0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_out_wr", {63'h0, out_wr}, 64'h0);
        check_output("reset_out_data", out_data, 64'h0);
        check_output("reset_decrypt_cnt", {32'h0, decrypt_cnt}, 64'h0);
        check_output("reset_bypass_cnt", {32'h0, bypass_cnt}, 64'h0);
        check_output("reset_in_rdy", {63'h0, in_rdy}, 64'h1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] UDP packet with known payload");
        gen_packet(0, 1, 7);
        pkt_data[pkt_first+5] = 64'h1234_000000000000;
        pkt_data[pkt_first+6] = 64'h0123456789ABCDEF;
        model_packet(32'hA5A5A5A5, 1'b1, dec);
        check_output("model_udp_dec", {63'h0, dec}, 64'h1);
        check_output("model_csum_word", mdl_data[pkt_first+5], 64'h0000_A5A5A5A5A5A5);
        check_output("model_payload_word", mdl_data[pkt_first+6], 64'hA486E0C22C0E684A);
        apply_stimulus(32'hA5A5A5A5, 1'b1, 0);
        wait_drain();
        check_output("udp_decrypt_cnt", {32'h0, decrypt_cnt}, 64'd1);
        check_output("udp_bypass_cnt", {32'h0, bypass_cnt}, 64'd0);

        $display("[TB] TCP and IPv6 packets bypass");
        gen_packet(1, 1, 8);
        model_packet(32'hA5A5A5A5, 1'b1, dec);
        check_output("model_tcp_dec", {63'h0, dec}, 64'h0);
        check_output("model_tcp_word", mdl_data[pkt_first+6], pkt_data[pkt_first+6]);
        apply_stimulus(32'hA5A5A5A5, 1'b1, 0);
        gen_packet(2, 2, 8);
        apply_stimulus(32'h5A5A1234, 1'b1, 0);
        wait_drain();
        check_output("bypass_bypass_cnt", {32'h0, bypass_cnt}, 64'd2);
        check_output("bypass_decrypt_cnt", {32'h0, decrypt_cnt}, 64'd1);

        $display("[TB] runt then UDP, and a disabled UDP packet");
        gen_packet(0, 1, 3);
        pkt_ctrl[pkt_len-1] = 8'h40;
        apply_stimulus(32'hDEADBEEF, 1'b1, 0);
        gen_packet(0, 1, 9);
        apply_stimulus(32'hCAFEF00D, 1'b1, 0);
        gen_packet(0, 1, 9);
        apply_stimulus(32'h11223344, 1'b0, 0);
        wait_drain();
        check_output("runt_bypass_cnt", {32'h0, bypass_cnt}, 64'd4);
        check_output("runt_decrypt_cnt", {32'h0, decrypt_cnt}, 64'd2);

        $display("[TB] toggling out_rdy with mid-payload key change");
        rdy_mode = 1;
        gen_packet(0, 1, 14);
        apply_stimulus(32'h0F1E2D3C, 1'b1, 2);
        wait_drain();
        check_output("stall_decrypt_cnt", {32'h0, decrypt_cnt}, 64'd3);

        $display("[TB] randomized packets");
        for (int p = 0; p < 40; p++) begin
            rdy_mode = $urandom % 3;
            gen_packet($urandom % 4, $urandom % 3, 1 + ($urandom % 12));
            apply_stimulus($urandom, ($urandom % 5) != 0, $urandom % 2);
        end
        wait_drain();

        $display("[TB] reset in the middle of a payload");
        rdy_mode = 0;
        wait_first_seen(pkts_started);
        gen_packet(0, 1, 10);
        key    = 32'h89ABCDEF;
        enable = 1'b1;
        model_packet(32'h89ABCDEF, 1'b1, dec);
        push_expected(pkt_first + 8);
        for (int i = 0; i < pkt_first + 8; i++) write_word(pkt_ctrl[i], pkt_data[i]);
        #2;
        reset = 1'b0;
        #1;
        check_output("midreset_out_wr", {63'h0, out_wr}, 64'h0);
        check_output("midreset_out_data", out_data, 64'h0);
        check_output("midreset_decrypt_cnt", {32'h0, decrypt_cnt}, 64'h0);
        check_output("midreset_bypass_cnt", {32'h0, bypass_cnt}, 64'h0);
        check_output("midreset_in_rdy", {63'h0, in_rdy}, 64'h1);
        expq.delete();
        first_seen   = 0;
        pkts_started = 0;
        model_dec    = 0;
        model_byp    = 0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        gen_packet(0, 2, 8);
        apply_stimulus(32'h13572468, 1'b1, 0);
        wait_drain();
        check_output("post_reset_decrypt_cnt", {32'h0, decrypt_cnt}, 64'd1);
        check_output("post_reset_bypass_cnt", {32'h0, bypass_cnt}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
